// File: rtl/relu6_act_packer.sv
// relu6_act_packer
//   Streaming consumer for ReLU6 activations. Each Q8.8 input, nominally in
//   [0, 6.0], is requantized to an unsigned 8-bit code (0.0 -> 0, 6.0 -> 255).
//   LANES codes are packed per output word. A partial word is flushed on in_last.
//   Ports:
//     clk, rst_n           rising-edge clock, synchronous active-low reset
//     in_valid/in_ready    input handshake; in_data (Q8.8), in_last (tile end)
//     out_valid/out_ready  output handshake; out_data (lane 0 in [7:0]),
//                          out_keep (per-lane byte valid), out_last
//     clamp_cnt            saturating count of inputs outside [0, 0x0600]
module relu6_act_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*LANES-1:0]    out_data,
  output logic [LANES-1:0]      out_keep,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  clamp_cnt
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW    = DATA_WIDTH + 8;
  localparam logic [DATA_WIDTH-1:0] SIX = DATA_WIDTH'(32'h0600);

  logic [IDX_W-1:0]     idx;
  logic [8*LANES-1:0]   pack;
  logic [8*LANES-1:0]   word_next;
  logic [LANES-1:0]     keep_next;
  logic [7:0]           code;
  logic [PW-1:0]        prod;
  logic [PW-1:0]        scaled;
  logic                 is_neg;
  logic                 clamp_evt;
  logic                 accept;
  logic                 complete;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign complete = accept & ((idx == IDX_W'(LANES - 1)) | in_last);

  // Requantize: x*85/512 with rounding, i.e. x * 255 / (6 * 256).
  always_comb begin
    is_neg    = in_data[DATA_WIDTH-1];
    clamp_evt = is_neg | (in_data > SIX);
    prod      = PW'(in_data) * PW'(85) + PW'(256);
    scaled    = prod >> 9;
    if (is_neg) begin
      code = '0;
    end else if (in_data >= SIX) begin
      code = '1;
    end else if (|scaled[PW-1:8]) begin
      code = '1;
    end else begin
      code = scaled[7:0];
    end
  end

  // Current pack register with the incoming code merged into lane[idx].
  always_comb begin
    word_next = pack;
    keep_next = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (idx == IDX_W'(i)) begin
        word_next[8*i +: 8] = code;
      end
      if (IDX_W'(i) <= idx) begin
        keep_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      clamp_cnt <= '0;
      idx       <= '0;
      pack      <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A completing word overrides the drop above, so a transfer and a new
      // word in the same cycle keep out_valid high with no bubble.
      if (accept) begin
        if (complete) begin
          out_valid <= 1'b1;
          out_data  <= word_next;
          out_keep  <= keep_next;
          out_last  <= in_last;
          pack      <= '0;
          idx       <= '0;
        end else begin
          pack      <= word_next;
          idx       <= idx + IDX_W'(1);
        end
        if (clamp_evt && !(&clamp_cnt)) begin
          clamp_cnt <= clamp_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_relu6_act_packer.sv
module tb_relu6_act_packer;

  localparam int LANES = 4;
  localparam int CW    = 3;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [8*LANES-1:0]  out_data;
  logic [LANES-1:0]    out_keep;
  logic                out_last;
  logic [CW-1:0]       clamp_cnt;

  relu6_act_packer #(
    .DATA_WIDTH (16),
    .LANES      (LANES),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .clamp_cnt (clamp_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  int          vectors;
  int          miscompares;
  logic [31:0] m_data;
  int          m_idx;
  int          exp_cnt;

  function automatic logic [7:0] qref(input logic [15:0] x);
    int unsigned p;
    if (x[15]) return 8'h00;
    if (x >= 16'h0600) return 8'hFF;
    p = (int'(x) * 85 + 256) / 512;
    if (p > 255) return 8'hFF;
    return 8'(p);
  endfunction

  function automatic bit is_clamp(input logic [15:0] x);
    return x[15] || (x > 16'h0600);
  endfunction

  task automatic model_accept(input logic [15:0] x, input logic last);
    exp_t e;
    m_data[8*m_idx +: 8] = qref(x);
    if (is_clamp(x) && exp_cnt < (1 << CW) - 1) exp_cnt++;
    if (m_idx == LANES - 1 || last) begin
      e.d = m_data;
      e.k = 4'((1 << (m_idx + 1)) - 1);
      e.l = last;
      sb.push_back(e);
      m_data = '0;
      m_idx  = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_idx   = 0;
    exp_cnt = 0;
    sb.delete();
  endtask

  // Present one input and hold it until accepted (bounded).
  task automatic send(input logic [15:0] x, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = x;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      model_accept(x, last);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_drain_timeout: %0d words outstanding, required 0", name, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0700;
    in_last   = 1'b1;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_keep !== '0 ||
        out_last !== 1'b0 || clamp_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%0b data=%h keep=%h last=%0b cnt=%0d required all 0",
               out_valid, out_data, out_keep, out_last, clamp_cnt);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_quantize();
    out_ready = 1'b0;
    send(16'h0000, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0300, 1'b0);
    send(16'h0600, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL quant_latency: out_valid=%0b in_ready=%0b required 1/0", out_valid, in_ready);
    end
    out_ready = 1'b1;
    wait_drain("quantize");
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL quant_empty: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_clamp();
    out_ready = 1'b1;
    send(16'hFF00, 1'b0);
    send(16'h0700, 1'b0);
    send(16'h0600, 1'b0);
    send(16'h0080, 1'b0);
    wait_drain("clamp");
    vectors++;
    if (clamp_cnt !== CW'(exp_cnt) || exp_cnt != 2) begin
      miscompares++;
      $display("FAIL clamp_count: clamp_cnt=%0d required %0d (2)", clamp_cnt, exp_cnt);
    end
  endtask

  task automatic test_partial_flush();
    out_ready = 1'b1;
    send(16'h0200, 1'b0);
    send(16'h0200, 1'b0);
    send(16'h0200, 1'b1);
    wait_drain("partial");
  endtask

  task automatic test_backpressure();
    time t0;
    logic [15:0] x;
    logic        l;
    out_ready = 1'b0;
    send(16'h0040, 1'b0);
    send(16'h0500, 1'b0);
    send(16'h8001, 1'b0);
    send(16'h05FF, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h0123;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== sb[0].d ||
          out_keep !== sb[0].k || out_last !== sb[0].l) begin
        miscompares++;
        $display("FAIL stall_stable: rdy=%0b vld=%0b data=%h keep=%h last=%0b required 0/1/%h/%h/%0b",
                 in_ready, out_valid, out_data, out_keep, out_last, sb[0].d, sb[0].k, sb[0].l);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 16; i++) begin
      x = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0600));
      l = ($urandom_range(0, 3) == 0);
      send(x, l);
    end
    vectors++;
    if (($time - t0) / 10 != 16) begin
      miscompares++;
      $display("FAIL throughput: %0d cycles for 16 inputs, required 16", ($time - t0) / 10);
    end
    for (int i = 0; i < 4; i++) send(16'h0300, 1'b1);
    wait_drain("backpressure");
  endtask

  task automatic test_sat_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send((i % 2 == 0) ? 16'h8000 : 16'h0601, 1'b0);
    send(16'h7FFF, 1'b1);
    wait_drain("saturate");
    vectors++;
    if (clamp_cnt !== '1 || exp_cnt != (1 << CW) - 1) begin
      miscompares++;
      $display("FAIL clamp_saturate: clamp_cnt=%0d required %0d", clamp_cnt, (1 << CW) - 1);
    end
    send(16'h0200, 1'b0);
    send(16'h0400, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || clamp_cnt !== '0) begin
        miscompares++;
        $display("FAIL midword_reset: out_valid=%0b clamp_cnt=%0d required 0/0", out_valid, clamp_cnt);
      end
    end
    @(posedge clk);
    #1;
    send(16'h0080, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0180, 1'b0);
    send(16'h0200, 1'b0);
    wait_drain("after_reset");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    out_ready   = 1'b0;
    model_reset();
    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL spurious_word: data=%h keep=%h last=%0b required no word",
                     out_data, out_keep, out_last);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (out_data !== e.d || out_keep !== e.k || out_last !== e.l) begin
              miscompares++;
              $display("FAIL out_word: data=%h keep=%h last=%0b required %h/%h/%0b",
                       out_data, out_keep, out_last, e.d, e.k, e.l);
            end
          end
        end
      end
    join_none
    test_reset();
    test_quantize();
    test_clamp();
    test_partial_flush();
    test_backpressure();
    test_sat_reset();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d words outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
